// File: rtl/noc_router_xy_if.sv
// Flit bus between the router and its five neighbours (N,E,S,W,Local), packed five ports wide.
// The slave side is the router; the master side is whatever drives and drains it.
interface noc_router_xy_if #(
   parameter int FLIT_W = 64
);
   logic [5*FLIT_W-1:0] flit_in;
   logic [4:0]          valid_in;
   logic [4:0]          ready_out;
   logic [5*FLIT_W-1:0] flit_out;
   logic [4:0]          valid_out;
   logic [4:0]          ready_in;

   modport master (
      output flit_in, valid_in, ready_in,
      input  ready_out, flit_out, valid_out
   );

   modport slave (
      input  flit_in, valid_in, ready_in,
      output ready_out, flit_out, valid_out
   );
endinterface

// File: rtl/noc_router_xy.sv
// 5-port XY mesh router: per-input FIFOs, X-then-Y routing from the head flit,
// round-robin arbitration per output and registered valid/ready outputs.
module noc_router_xy #(
   parameter int FLIT_W     = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int X_W        = 4,
   parameter int Y_W        = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [X_W-1:0] my_x,
   input  logic [Y_W-1:0] my_y,
   noc_router_xy_if.slave bus
);

   localparam int NP    = 5;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [FLIT_W-1:0] mem      [NP][FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr   [NP];
   logic [PTR_W-1:0]  rd_ptr   [NP];
   logic [CNT_W-1:0]  count    [NP];
   logic [FLIT_W-1:0] head     [NP];
   logic [FLIT_W-1:0] out_flit [NP];
   logic [2:0]        route    [NP];
   logic [2:0]        rr_ptr   [NP];
   logic [2:0]        gnt_idx  [NP];

   logic [NP-1:0] full;
   logic [NP-1:0] req;
   logic [NP-1:0] accept;
   logic [NP-1:0] push;
   logic [NP-1:0] pop;
   logic [NP-1:0] out_free;
   logic [NP-1:0] gnt_valid;
   logic [NP-1:0] out_valid;

   function automatic logic [2:0] wrap5(input logic [2:0] base, input logic [2:0] off);
      logic [3:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 4'd5) sum = sum - 4'd5;
      return sum[2:0];
   endfunction

   // A full FIFO refuses even if it pops this cycle, so ready never depends on the grant.
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         full[i]   = (count[i] == CNT_W'(FIFO_DEPTH));
         req[i]    = (count[i] != '0);
         accept[i] = !rst && !full[i];
         push[i]   = bus.valid_in[i] && accept[i];
         head[i]   = mem[i][rd_ptr[i]];
      end
   end

   always_comb begin
      logic [X_W-1:0] dx;
      logic [Y_W-1:0] dy;
      dx = '0;
      dy = '0;
      for (int i = 0; i < NP; i++) begin
         route[i] = 3'd4;
         dx = head[i][FLIT_W-1 -: X_W];
         dy = head[i][FLIT_W-X_W-1 -: Y_W];
         if (dx > my_x)      route[i] = 3'd1;
         else if (dx < my_x) route[i] = 3'd3;
         else if (dy < my_y) route[i] = 3'd0;
         else if (dy > my_y) route[i] = 3'd2;
      end
   end

   assign out_free = ~out_valid | bus.ready_in;

   always_comb begin
      logic [2:0] cand;
      cand      = '0;
      gnt_valid = '0;
      for (int o = 0; o < NP; o++) begin
         gnt_idx[o] = '0;
         for (int k = 0; k < NP; k++) begin
            cand = wrap5(rr_ptr[o], 3'(k));
            if (out_free[o] && !gnt_valid[o] && req[cand] && route[cand] == 3'(o)) begin
               gnt_valid[o] = 1'b1;
               gnt_idx[o]   = cand;
            end
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int o = 0; o < NP; o++) begin
         if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= bus.flit_in[i*FLIT_W +: FLIT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= '0;
         for (int i = 0; i < NP; i++) begin
            wr_ptr[i]   <= '0;
            rd_ptr[i]   <= '0;
            count[i]    <= '0;
            out_flit[i] <= '0;
            rr_ptr[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         end
         // A stalled output keeps flit and valid; an idle free output drops valid but keeps the flit.
         for (int o = 0; o < NP; o++) begin
            if (out_free[o]) begin
               out_valid[o] <= gnt_valid[o];
               if (gnt_valid[o]) begin
                  out_flit[o] <= head[gnt_idx[o]];
                  rr_ptr[o]   <= wrap5(gnt_idx[o], 3'd1);
               end
            end
         end
      end
   end

   assign bus.ready_out = accept;
   assign bus.valid_out = out_valid;

   for (genvar o = 0; o < NP; o++) begin : g_pack
      assign bus.flit_out[o*FLIT_W +: FLIT_W] = out_flit[o];
   end

endmodule
